pe_context_sequencer: RTL

- Upstream configuration source for one PE_6_bus tile. Drives its 22-bit `configuration` input.
- Holds a small register-file program of context words, each with a per-context hold count.
- On `start`, steps through contexts 0..N-1, holding each for `hold+1` cycles, with optional looping.
- Outputs an all-zero (NOP) configuration whenever it is not running.

---
 rtl/pe_cfg_pkg.sv | 29 ++
 rtl/pe_context_mem.sv | 44 ++++
 rtl/pe_context_sequencer.sv | 135 +++++++++++++
 3 files changed

// File: rtl/pe_cfg_pkg.sv
// Shared definitions for PE configuration words and the context sequencer FSM.
package pe_cfg_pkg;

  localparam int CFG_W = 22;

  localparam logic [CFG_W-1:0] NOP_CFG = '0;

  // Field layout of one PE configuration word, MSB first.
  typedef struct packed {
    logic [5:0] route;
    logic [3:0] out_mask;
    logic [3:0] src_b;
    logic [3:0] src_a;
    logic [3:0] opcode;
  } pe_cfg_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } seq_state_t;

  function automatic logic [3:0] cfg_opcode(input logic [CFG_W-1:0] cfg);
    pe_cfg_t f;
    f = pe_cfg_t'(cfg);
    return f.opcode;
  endfunction

endpackage

// File: rtl/pe_context_mem.sv
// Context register file: DEPTH slots of {word, hold}, sync write, two async read ports.
// Port A serves the restart target (slot 0), port B serves the following slot.
module pe_context_mem
  import pe_cfg_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3,
  parameter int HOLD_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [CFG_W-1:0]  i_wr_data,
  input  logic [HOLD_W-1:0] i_wr_hold,
  input  logic [ADDR_W-1:0] i_rd_a_addr,
  output logic [CFG_W-1:0]  o_rd_a_data,
  output logic [HOLD_W-1:0] o_rd_a_hold,
  input  logic [ADDR_W-1:0] i_rd_b_addr,
  output logic [CFG_W-1:0]  o_rd_b_data,
  output logic [HOLD_W-1:0] o_rd_b_hold
);

  logic [CFG_W-1:0]  r_data [DEPTH];
  logic [HOLD_W-1:0] r_hold [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_data[i] <= '0;
        r_hold[i] <= '0;
      end
    end else if (i_wr_en) begin
      r_data[i_wr_addr] <= i_wr_data;
      r_hold[i_wr_addr] <= i_wr_hold;
    end
  end

  assign o_rd_a_data = r_data[i_rd_a_addr];
  assign o_rd_a_hold = r_hold[i_rd_a_addr];
  assign o_rd_b_data = r_data[i_rd_b_addr];
  assign o_rd_b_hold = r_hold[i_rd_b_addr];

endmodule

// File: rtl/pe_context_sequencer.sv
// Steps a PE tile through a stored program of context words, each held hold+1 cycles.
// First word appears the cycle after start; NOP (all-zero) whenever not running.
module pe_context_sequencer
  import pe_cfg_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3,
  parameter int HOLD_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_wr_en,
  input  logic [ADDR_W-1:0] cfg_wr_addr,
  input  logic [CFG_W-1:0]  cfg_wr_data,
  input  logic [HOLD_W-1:0] cfg_wr_hold,
  input  logic              start,
  input  logic              stop,
  input  logic [ADDR_W:0]   num_ctx,
  input  logic              loop_en,
  output logic [CFG_W-1:0]  configuration,
  output logic              cfg_valid,
  output logic [ADDR_W-1:0] ctx_idx,
  output logic              busy,
  output logic              done
);

  seq_state_t        r_state;
  logic [ADDR_W:0]   r_num_len;
  logic [HOLD_W-1:0] r_hold_cnt;
  logic [ADDR_W-1:0] r_ctx_idx;
  logic [CFG_W-1:0]  r_cfg;
  logic              r_vld;
  logic              r_busy;
  logic              r_done;

  logic              w_mem_wr;
  logic [ADDR_W-1:0] w_nxt_idx;
  logic [CFG_W-1:0]  w_first_data;
  logic [HOLD_W-1:0] w_first_hold;
  logic [CFG_W-1:0]  w_nxt_data;
  logic [HOLD_W-1:0] w_nxt_hold;
  logic              w_last;
  logic [ADDR_W:0]   w_num_clamp;

  // The program must not change underneath a running sequence.
  assign w_mem_wr  = cfg_wr_en && (r_state != RUN);
  assign w_nxt_idx = r_ctx_idx + ADDR_W'(1);
  assign w_last    = ({1'b0, r_ctx_idx} == (r_num_len - (ADDR_W+1)'(1)));
  assign w_num_clamp = (num_ctx > (ADDR_W+1)'(DEPTH)) ? (ADDR_W+1)'(DEPTH) : num_ctx;

  pe_context_mem #(
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W),
    .HOLD_W(HOLD_W)
  ) u_mem (
    .clk        (clk),
    .rst        (rst),
    .i_wr_en    (w_mem_wr),
    .i_wr_addr  (cfg_wr_addr),
    .i_wr_data  (cfg_wr_data),
    .i_wr_hold  (cfg_wr_hold),
    .i_rd_a_addr('0),
    .o_rd_a_data(w_first_data),
    .o_rd_a_hold(w_first_hold),
    .i_rd_b_addr(w_nxt_idx),
    .o_rd_b_data(w_nxt_data),
    .o_rd_b_hold(w_nxt_hold)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_num_len  <= '0;
      r_hold_cnt <= '0;
      r_ctx_idx  <= '0;
      r_cfg      <= NOP_CFG;
      r_vld      <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (start && (num_ctx != '0)) begin
            r_state    <= RUN;
            r_num_len  <= w_num_clamp;
            r_ctx_idx  <= '0;
            r_cfg      <= w_first_data;
            r_hold_cnt <= w_first_hold;
            r_vld      <= 1'b1;
            r_busy     <= 1'b1;
          end
        end
        RUN: begin
          if (stop) begin
            r_state <= IDLE;
            r_cfg   <= NOP_CFG;
            r_vld   <= 1'b0;
            r_busy  <= 1'b0;
          end else if (r_hold_cnt != '0) begin
            r_hold_cnt <= r_hold_cnt - HOLD_W'(1);
          end else if (!w_last) begin
            r_ctx_idx  <= w_nxt_idx;
            r_cfg      <= w_nxt_data;
            r_hold_cnt <= w_nxt_hold;
          end else if (loop_en) begin
            r_ctx_idx  <= '0;
            r_cfg      <= w_first_data;
            r_hold_cnt <= w_first_hold;
          end else begin
            r_state <= DONE;
            r_cfg   <= NOP_CFG;
            r_vld   <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_done  <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign configuration = r_cfg;
  assign cfg_valid     = r_vld;
  assign ctx_idx       = r_ctx_idx;
  assign busy          = r_busy;
  assign done          = r_done;

endmodule
